// File: rtl/smul_pkg.sv
// Shared definitions for the multiply write-back path: lane geometry,
// default vector/index widths and the packed FIFO entry layout.
package smul_pkg;

  // Product vector geometry: 16 lanes of 16 bits each
  localparam int LANE_W = 16;
  localparam int LANES  = 16;
  localparam int DW_DEF = LANE_W * LANES;
  localparam int AW_DEF = 3;

  // One buffered write-back request as produced by the multiply stage
  typedef struct packed {
    logic [DW_DEF-1:0] product;
    logic              ovf;
    logic [AW_DEF-1:0] dst;
  } smul_entry_t;

  localparam int ENTRY_W_DEF = $bits(smul_entry_t);

  // Width of a packed {product, ovf, dst} entry for arbitrary DW/AW
  function automatic int entry_width(input int dw, input int aw);
    return dw + 1 + aw;
  endfunction

endpackage

// File: rtl/smul_fifo.sv
// Generic DEPTH-entry FIFO with read/write pointers and an occupancy count.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Both handshake outputs come from registered state only; there is no
// combinational path from pop_ready to push_ready and no write-to-read bypass.
module smul_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A full FIFO refuses the push even if a pop happens in the same cycle,
  // which keeps push_ready independent of pop_ready.
  assign w_push = push_valid && !w_full;
  assign w_pop  = pop_ready  && !w_empty;

  assign push_ready = !w_full;
  assign pop_valid  = !w_empty;
  assign pop_data   = r_mem[r_rd_ptr];

  // Storage write; contents need no reset because pop_valid gates them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Write pointer advances on every accepted push, wrapping modulo DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + PW'(1);
    end
  end

  // Read pointer advances on every accepted pop, wrapping modulo DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/smul_wb_stage.sv
// Write-back buffer between the SIMD multiply stage and the vector register
// file. Results are queued in smul_fifo and presented from the head entry.
// Optional feature: define SMUL_STICKY_OVF_EN to build the sticky overflow
// status flag; without it ovf_sticky is constant 0 and ovf_clr is unused.
module smul_wb_stage
  import smul_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_product,
  input  logic          in_ovf,
  input  logic [AW-1:0] in_dst,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [DW-1:0] wb_data,
  output logic [AW-1:0] wb_dst,
  output logic          wb_ovf,
  output logic          ovf_sticky,
  input  logic          ovf_clr
);

  localparam int EW = entry_width(DW, AW);

  logic [EW-1:0] w_push_entry;
  logic [EW-1:0] w_head_entry;
  logic          w_pop_fire;

  // Entry layout matches smul_entry_t: {product, ovf, dst}
  assign w_push_entry = {in_product, in_ovf, in_dst};

  smul_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (w_push_entry),
    .pop_valid  (wb_valid),
    .pop_ready  (wb_ready),
    .pop_data   (w_head_entry)
  );

  // Product bits are passed through untouched
  assign wb_data = w_head_entry[EW-1 -: DW];
  assign wb_ovf  = w_head_entry[AW];
  assign wb_dst  = w_head_entry[AW-1:0];

  assign w_pop_fire = wb_valid && wb_ready;

`ifdef SMUL_STICKY_OVF_EN
  logic r_ovf_sticky;

  // Sticky overflow: a popped overflowing entry sets it and beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_pop_fire && wb_ovf) begin
      r_ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  assign ovf_sticky = r_ovf_sticky;
`else
  logic w_unused_sticky;

  // Feature absent: no state, flag tied low, clear and pop event unused
  assign w_unused_sticky = ovf_clr ^ w_pop_fire;
  assign ovf_sticky      = 1'b0;
`endif

endmodule

// File: tb/tb_smul_wb_stage.sv
// Self-checking bench for smul_wb_stage: a queue-based reference model is
// compared against the DUT on every falling edge, plus directed literal checks.
// Build with or without SMUL_STICKY_OVF_EN.
module tb_smul_wb_stage;
  import smul_pkg::*;

  localparam int DEPTH = 2;
  localparam int DW    = DW_DEF;
  localparam int AW    = AW_DEF;
`ifdef SMUL_STICKY_OVF_EN
  localparam logic STICKY_ON = 1'b1;
`else
  localparam logic STICKY_ON = 1'b0;
`endif

  logic          clk        = 1'b0;
  logic          rst        = 1'b0;
  logic          in_valid   = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_product = '0;
  logic          in_ovf     = 1'b0;
  logic [AW-1:0] in_dst     = '0;
  logic          wb_valid;
  logic          wb_ready   = 1'b0;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] wb_dst;
  logic          wb_ovf;
  logic          ovf_sticky;
  logic          ovf_clr    = 1'b0;

  smul_wb_stage #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_ovf     (in_ovf),
    .in_dst     (in_dst),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_data    (wb_data),
    .wb_dst     (wb_dst),
    .wb_ovf     (wb_ovf),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] make_prod(input int tag);
    logic [DW-1:0] p;
    p = '0;
    for (int i = 0; i < LANES; i++) p[i*LANE_W +: LANE_W] = 16'(tag * 16 + i);
    return p;
  endfunction

  // ---------------- reference model: a plain queue of entries ----------------
  smul_entry_t mq[$];
  logic        m_sticky = 1'b0;
  logic        m_push;
  logic        m_pop;
  logic        m_head_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_sticky = 1'b0;
    end else begin
      m_push     = in_valid && (mq.size() < DEPTH);
      m_pop      = wb_ready && (mq.size() > 0);
      m_head_ovf = (mq.size() > 0) ? mq[0].ovf : 1'b0;
      if (STICKY_ON) begin
        if (m_pop && m_head_ovf) m_sticky = 1'b1;
        else if (ovf_clr)        m_sticky = 1'b0;
      end
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back('{product: in_product, ovf: in_ovf, dst: in_dst});
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("m_in_ready", DW'(in_ready), DW'(mq.size() != DEPTH));
    chk("m_wb_valid", DW'(wb_valid), DW'(mq.size() != 0));
    chk("m_sticky",   DW'(ovf_sticky), DW'(m_sticky));
    if (mq.size() > 0) begin
      chk("m_wb_data", wb_data, mq[0].product);
      chk("m_wb_dst",  DW'(wb_dst), DW'(mq[0].dst));
      chk("m_wb_ovf",  DW'(wb_ovf), DW'(mq[0].ovf));
    end
  end

  // Record lane 0 of every DUT pop to check order and count
  logic [15:0] popped[$];
  always @(posedge clk) begin
    if (!rst && wb_valid && wb_ready) popped.push_back(wb_data[15:0]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] p1;
  int            pushed_n;
  logic          acc;

  initial begin
    // Reset
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", DW'(in_ready), DW'(1));
    chk("rst_wb_valid", DW'(wb_valid), DW'(0));
    chk("rst_sticky",   DW'(ovf_sticky), DW'(0));
    $display("[%0t] reset held", $time);
    @(negedge clk);
    rst = 1'b0;

    // Single push with wb_ready high: visible next cycle, popped one later
    p1 = 256'h000A0014001E;
    in_valid = 1'b1; in_product = p1; in_dst = 3'd3; in_ovf = 1'b0; wb_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_wb_valid", DW'(wb_valid), DW'(1));
    chk("t1_wb_data",  wb_data, p1);
    chk("t1_wb_dst",   DW'(wb_dst), DW'(3));
    $display("[%0t] single push dst=3 presented", $time);
    @(negedge clk);
    chk("t1_popped", DW'(wb_valid), DW'(0));
    $display("[%0t] single entry popped", $time);

    // Three pushes with wb_ready low
    wb_ready = 1'b0;
    in_valid = 1'b1; in_product = make_prod(1); in_dst = 3'd1;
    @(negedge clk);
    chk("t2_ready_after1", DW'(in_ready), DW'(1));
    chk("t2_head_after1",  DW'(wb_dst), DW'(1));
    $display("[%0t] push A dst=1", $time);
    in_product = make_prod(2); in_dst = 3'd2;
    @(negedge clk);
    chk("t2_ready_after2", DW'(in_ready), DW'(0));
    chk("t2_head_after2",  DW'(wb_dst), DW'(1));
    $display("[%0t] push B dst=2, full", $time);
    in_product = make_prod(3); in_dst = 3'd4;
    @(negedge clk);
    chk("t2_held_ready", DW'(in_ready), DW'(0));
    chk("t2_held_data",  wb_data, make_prod(1));
    $display("[%0t] push C held", $time);

    // Full FIFO, in_valid and wb_ready together: pop only
    wb_ready = 1'b1;
    @(negedge clk);
    chk("t3_head_after_pop", DW'(wb_dst), DW'(2));
    chk("t3_ready_count1",   DW'(in_ready), DW'(1));
    $display("[%0t] full pop, push rejected", $time);
    wb_ready = 1'b0;
    @(negedge clk);
    chk("t3_c_accepted", DW'(in_ready), DW'(0));
    chk("t3_head_still", DW'(wb_dst), DW'(2));
    $display("[%0t] push C accepted", $time);
    in_valid = 1'b0; wb_ready = 1'b1;
    @(negedge clk);
    chk("t3_head_c", DW'(wb_dst), DW'(4));
    @(negedge clk);
    chk("t3_drained", DW'(wb_valid), DW'(0));
    $display("[%0t] drained", $time);

    // Sticky overflow: set wins over simultaneous clear
    wb_ready = 1'b0;
    in_valid = 1'b1; in_product = make_prod(7); in_dst = 3'd5; in_ovf = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_ovf = 1'b0;
    chk("t4_wb_ovf", DW'(wb_ovf), DW'(1));
    wb_ready = 1'b1; ovf_clr = 1'b1;
    @(negedge clk);
    chk("t4_sticky_set", DW'(ovf_sticky), DW'(STICKY_ON));
    $display("[%0t] ovf pop with clear, sticky=%0d", $time, ovf_sticky);
    wb_ready = 1'b0;
    @(negedge clk);
    chk("t4_sticky_clr", DW'(ovf_sticky), DW'(0));
    ovf_clr = 1'b0;
    $display("[%0t] sticky cleared", $time);

    // Asynchronous reset with two entries stored
    in_valid = 1'b1; in_product = make_prod(50); in_dst = 3'd6;
    @(negedge clk);
    in_product = make_prod(51); in_dst = 3'd7;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_full_before", DW'(in_ready), DW'(0));
    popped.delete();
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", DW'(wb_valid), DW'(0));
    chk("t5_async_ready", DW'(in_ready), DW'(1));
    $display("[%0t] async reset with 2 entries", $time);
    @(negedge clk);
    rst = 1'b0; wb_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_no_stale_valid", DW'(wb_valid), DW'(0));
    chk("t5_no_stale_pops",  DW'(popped.size()), DW'(0));

    // Streaming with wb_ready toggling
    popped.delete();
    pushed_n = 0;
    for (int i = 0; i < 10; i++) begin
      wb_ready   = (i % 2) == 1;
      in_valid   = 1'b1;
      in_product = make_prod(100 + pushed_n);
      in_dst     = AW'(pushed_n);
      acc        = in_ready;
      @(negedge clk);
      if (acc) pushed_n++;
      $display("[%0t] stream cycle %0d wb_ready=%0d pushed=%0d", $time, i, wb_ready, pushed_n);
    end
    in_valid = 1'b0; wb_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_pushed", DW'(pushed_n), DW'(6));
    chk("t6_popped", DW'(popped.size()), DW'(6));
    for (int j = 0; j < popped.size(); j++) begin
      chk("t6_order", DW'(popped[j]), DW'(16'((100 + j) * 16)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/smul_wb_stage.md
SMUL_WB_STAGE -- requirements
Module: smul_wb_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter DW, default 256, meaning product vector width (16 lanes x 16 bits).
REQ-003 SHALL have parameter AW, default 3, meaning destination vector-register index width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, meaning the multiply-stage result is present.
REQ-007 SHALL have port in_ready, output, 1, meaning the stage accepts a result this cycle.
REQ-008 SHALL have port in_product, input, DW, the multiply-stage product vector.
REQ-009 SHALL have port in_ovf, input, 1, the multiply-stage overflow flag.
REQ-010 SHALL have port in_dst, input, AW, the destination register index.
REQ-011 SHALL have port wb_valid, output, 1, meaning a write-back request is pending.
REQ-012 SHALL have port wb_ready, input, 1, meaning the register-file write port is accepting.
REQ-013 SHALL have port wb_data, output, DW, the write-back vector.
REQ-014 SHALL have port wb_dst, output, AW, the write-back register index.
REQ-015 SHALL have port wb_ovf, output, 1, the overflow flag of the head entry.
REQ-016 SHALL have port ovf_sticky, output, 1, the sticky overflow status.
REQ-017 SHALL have port ovf_clr, input, 1, a synchronous clear of ovf_sticky.

Function
REQ-018 SHALL implement a DEPTH-entry FIFO of {product, ovf, dst} with read pointer, write pointer and occupancy count.
REQ-019 SHALL push when in_valid and in_ready are both high, and pop when wb_valid and wb_ready are both high.
REQ-020 SHALL drive in_ready = (count != DEPTH), registered-state-derived, with no combinational path from wb_ready.
REQ-021 SHALL drive wb_valid = (count != 0), and drive wb_data, wb_dst and wb_ovf from the head entry.
REQ-022 SHALL give a latency of one cycle from push to wb_valid when the FIFO is empty, with no bypass.
REQ-023 SHALL, on simultaneous push and pop when neither full nor empty, leave count unchanged and advance both pointers.
REQ-024 SHALL reject a push when full, even if a pop occurs in the same cycle.
REQ-025 SHALL ignore a pop request when empty.
REQ-026 SHALL wrap pointers modulo DEPTH.
REQ-027 SHALL hold head outputs stable while wb_valid is high and wb_ready is low.
REQ-028 SHALL not modify the product data (pass-through width DW).

Reset
REQ-029 SHALL, on rst high (asynchronous), clear pointers, count and ovf_sticky to 0; wb_valid = 0 and in_ready = 1 while rst is high.
REQ-030 SHALL, on reset mid-operation, discard all stored entries; wb_data contents are don't-care while wb_valid = 0.

Configuration
REQ-031 SHALL, with SMUL_STICKY_OVF_EN defined, set ovf_sticky on any pop whose head entry has ovf = 1, and clear it when ovf_clr is high; a set in the same cycle as a clear SHALL win.
REQ-032 SHALL, without SMUL_STICKY_OVF_EN, tie ovf_sticky to 0, ignore ovf_clr, and generate no sticky flop.

Structure
REQ-033 SHALL take the defaults for DW, AW, the lane width (16) and the lane count (16) from shared package smul_pkg, together with the entry struct typedef {product, ovf, dst}.
REQ-034 SHALL be implemented as one sub-module, smul_fifo (generic storage plus pointers), with the sticky logic and port mapping kept in smul_wb_stage.

Verification
REQ-035 SHALL cover: single push of product 0x...000A0014001E, dst 3, with wb_ready = 1 -> wb_valid asserts the next cycle with wb_data matching, wb_dst = 3, popped one cycle later.
REQ-036 SHALL cover: three pushes with wb_ready = 0 -> in_ready drops after the second push; the third push is held; outputs stay on entry 0.
REQ-037 SHALL cover: full FIFO with in_valid = 1 and wb_ready = 1 in the same cycle -> one pop, no push, count = 1, and the push accepted in the following cycle.
REQ-038 SHALL cover: with SMUL_STICKY_OVF_EN, pop an entry with ovf = 1 while ovf_clr = 1 -> ovf_sticky = 1; ovf_clr alone the next cycle -> 0. Without the macro -> ovf_sticky stays 0.
REQ-039 SHALL cover: rst asserted mid-stream with 2 entries stored -> wb_valid = 0 and in_ready = 1 immediately (asynchronous), with no stale entry popped after release.
REQ-040 SHALL cover: 10 streaming push/pop cycles with wb_ready toggling -> pointer wrap, order preserved, no loss or duplication.
